// File: rtl/fifo_rr_reader.sv
// Round-robin reader draining CH_AMOUNT show-ahead FIFOs into one valid/ready stream.
// Each grant pops up to BURST_LEN words from a single channel, then re-arbitrates.
module fifo_rr_reader #(
  parameter int CH_AMOUNT  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CH_WIDTH   = $clog2(CH_AMOUNT)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic [CH_AMOUNT-1:0]             fifo_empty_i,
  input  logic [CH_AMOUNT*DATA_WIDTH-1:0]  fifo_data_i,
  output logic [CH_AMOUNT-1:0]             fifo_rd_o,
  output logic [DATA_WIDTH-1:0]            data_o,
  output logic [CH_WIDTH-1:0]              ch_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             busy_o
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                               state, state_nxt;
  logic [CH_WIDTH-1:0]                  grant, last_grant, rr_sel, rr_cand;
  logic                                 rr_found;
  logic [CNT_W-1:0]                     burst_cnt;
  logic [CH_AMOUNT-1:0][DATA_WIDTH-1:0] data_arr;
  logic                                 slot_free, pop, burst_done;

  assign data_arr   = fifo_data_i;
  assign slot_free  = !valid_o || ready_i;
  assign pop        = (state == GRANT) && slot_free && !fifo_empty_i[grant];
  assign burst_done = (burst_cnt + CNT_W'(1)) == CNT_W'(BURST_LEN);
  assign busy_o     = (state == GRANT);

  // Walk channels starting one past last_grant, wrapping at CH_AMOUNT (need not be a power of 2).
  always_comb begin
    rr_found = 1'b0;
    rr_sel   = '0;
    rr_cand  = last_grant;
    for (int i = 0; i < CH_AMOUNT; i++) begin
      rr_cand = (rr_cand == CH_WIDTH'(CH_AMOUNT - 1)) ? '0 : rr_cand + CH_WIDTH'(1);
      if (!rr_found && !fifo_empty_i[rr_cand]) begin
        rr_found = 1'b1;
        rr_sel   = rr_cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    fifo_rd_o = '0;
    case (state)
      IDLE:  if (rr_found) state_nxt = GRANT;
      GRANT: begin
        if (pop) fifo_rd_o[grant] = 1'b1;
        if (fifo_empty_i[grant] || (pop && burst_done)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CH_WIDTH'(CH_AMOUNT - 1);
      burst_cnt  <= '0;
      valid_o    <= 1'b0;
      data_o     <= '0;
      ch_o       <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && rr_found) begin
        grant      <= rr_sel;
        last_grant <= rr_sel;
        burst_cnt  <= '0;
      end
      // Output slot: load on pop, drop valid once the sink took the word.
      if (pop) begin
        data_o    <= data_arr[grant];
        ch_o      <= grant;
        valid_o   <= 1'b1;
        burst_cnt <= burst_cnt + CNT_W'(1);
      end else if (slot_free) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_reader.sv
// Directed bench for fifo_rr_reader: bench-side show-ahead FIFO queues feed the DUT,
// outputs are compared against hand-computed values one cycle at a time.
module tb_fifo_rr_reader;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [3:0]  fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic [3:0]  fifo_rd_o;
  logic [7:0]  data_o;
  logic [1:0]  ch_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  logic [7:0] q [4][$];

  fifo_rr_reader #(.CH_AMOUNT(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i),
    .fifo_rd_o(fifo_rd_o), .data_o(data_o), .ch_o(ch_o), .valid_o(valid_o),
    .ready_i(ready_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int k = 0; k < 4; k++) begin
      fifo_empty_i[k]        = (q[k].size() == 0);
      fifo_data_i[k*8 +: 8]  = (q[k].size() != 0) ? q[k][0] : 8'h00;
    end
    #1;
  endtask

  // One clock: sample pops before the edge, retire them from the queues after it.
  task automatic tick();
    logic [3:0] rd_s;
    @(negedge clk_i);
    rd_s = fifo_rd_o;
    chk("rd_onehot", {31'd0, $onehot0(rd_s)}, 32'd1);
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 4; k++)
      if (rd_s[k]) begin
        chk("pop_nonempty", {31'd0, q[k].size() != 0}, 32'd1);
        if (q[k].size() != 0) void'(q[k].pop_front());
      end
    refresh();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    chk({tag, "_valid"}, {31'd0, valid_o}, {31'd0, v});
    if (v) begin
      chk({tag, "_data"}, {24'd0, data_o}, {24'd0, d});
      chk({tag, "_ch"}, {30'd0, ch_o}, {30'd0, c});
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    ready_i = 1'b1;
    q[0].push_back(8'h10);
    q[2].push_back(8'h20);
    refresh();

    // Reset and priority: empty = 4'b1010
    tick(); tick();
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_ch", {30'd0, ch_o}, 32'd0);
    chk("rst_rd", {28'd0, fifo_rd_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst_n_i = 1'b1; #1;
    chk("idle_busy", {31'd0, busy_o}, 32'd0);
    tick();
    chk("prio_busy", {31'd0, busy_o}, 32'd1);
    chk("prio_rd0", {28'd0, fifo_rd_o}, 32'h1);
    tick();  chk_out("prio_w0", 1'b1, 8'h10, 2'd0);
    chk("prio_rd_empty", {28'd0, fifo_rd_o}, 32'h0);
    tick();  chk_out("prio_exit", 1'b0, 8'h00, 2'd0);
    chk("prio_exit_busy", {31'd0, busy_o}, 32'd0);
    tick();  chk("prio_rd2", {28'd0, fifo_rd_o}, 32'h4);
    tick();  chk_out("prio_w2", 1'b1, 8'h20, 2'd2);
    tick();  chk_out("prio_exit2", 1'b0, 8'h00, 2'd0);

    // Burst limit: six words on ch1
    for (int i = 0; i < 6; i++) q[1].push_back(8'hA0 + 8'(i));
    refresh();
    tick();  chk("burst_rd", {28'd0, fifo_rd_o}, 32'h2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("burst_w", 1'b1, 8'hA0 + 8'(i), 2'd1);
      chk("burst_busy", {31'd0, busy_o}, {31'd0, i != 3});
    end
    tick();  chk_out("burst_gap", 1'b0, 8'h00, 2'd0);
    chk("burst_regrant", {28'd0, fifo_rd_o}, 32'h2);
    tick();  chk_out("burst_w4", 1'b1, 8'hA4, 2'd1);
    tick();  chk_out("burst_w5", 1'b1, 8'hA5, 2'd1);
    tick();  chk_out("burst_end", 1'b0, 8'h00, 2'd0);

    // Round robin from a fresh reset so channel 0 leads
    rst_n_i = 1'b0; #1;
    tick();
    rst_n_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      q[k].push_back(8'(k * 16));
      q[k].push_back(8'(k * 16 + 1));
    end
    refresh();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();  chk_out("rr_w0", 1'b1, 8'(k * 16), 2'(k));
      tick();  chk_out("rr_w1", 1'b1, 8'(k * 16 + 1), 2'(k));
      tick();  chk_out("rr_exit", 1'b0, 8'h00, 2'd0);
      if (k < 3) begin
        tick();
        chk("rr_next", {28'd0, fifo_rd_o}, 32'h1 << (k + 1));
      end
    end
    q[0].push_back(8'h0A);
    q[3].push_back(8'h3A);
    refresh();
    tick();  chk("rr_wrap_rd", {28'd0, fifo_rd_o}, 32'h1);
    tick();  chk_out("rr_wrap_w", 1'b1, 8'h0A, 2'd0);
    tick();
    tick();  chk("rr_wrap_rd3", {28'd0, fifo_rd_o}, 32'h8);
    tick();  chk_out("rr_wrap_w3", 1'b1, 8'h3A, 2'd3);
    tick();  chk_out("rr_wrap_end", 1'b0, 8'h00, 2'd0);

    // Backpressure on ch1
    for (int i = 0; i < 3; i++) q[1].push_back(8'hB0 + 8'(i));
    refresh();
    tick();  chk("bp_rd", {28'd0, fifo_rd_o}, 32'h2);
    tick();  chk_out("bp_w0", 1'b1, 8'hB0, 2'd1);
    ready_i = 1'b0; #1;
    chk("bp_rd_hold", {28'd0, fifo_rd_o}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_out("bp_hold", 1'b1, 8'hB0, 2'd1);
      chk("bp_rd_stall", {28'd0, fifo_rd_o}, 32'h0);
    end
    ready_i = 1'b1; #1;
    chk("bp_rd_resume", {28'd0, fifo_rd_o}, 32'h2);
    tick();  chk_out("bp_w1", 1'b1, 8'hB1, 2'd1);
    tick();  chk_out("bp_w2", 1'b1, 8'hB2, 2'd1);
    tick();  chk_out("bp_end", 1'b0, 8'h00, 2'd0);

    // Early exit: ch2 holds two words
    q[2].push_back(8'hC0);
    q[2].push_back(8'hC1);
    refresh();
    tick();  chk("ee_rd", {28'd0, fifo_rd_o}, 32'h4);
    tick();  chk_out("ee_w0", 1'b1, 8'hC0, 2'd2);
    tick();  chk_out("ee_w1", 1'b1, 8'hC1, 2'd2);
    chk("ee_rd_empty", {28'd0, fifo_rd_o}, 32'h0);
    chk("ee_busy", {31'd0, busy_o}, 32'd1);
    tick();  chk("ee_idle", {31'd0, busy_o}, 32'd0);
    chk("ee_valid", {31'd0, valid_o}, 32'd0);

    // Reset mid-burst on ch2
    for (int i = 0; i < 4; i++) q[2].push_back(8'hD0 + 8'(i));
    refresh();
    tick();  chk("mr_rd", {28'd0, fifo_rd_o}, 32'h4);
    tick();  chk_out("mr_w0", 1'b1, 8'hD0, 2'd2);
    tick();  chk_out("mr_w1", 1'b1, 8'hD1, 2'd2);
    rst_n_i = 1'b0; #1;
    chk("mr_valid", {31'd0, valid_o}, 32'd0);
    chk("mr_data", {24'd0, data_o}, 32'd0);
    chk("mr_busy", {31'd0, busy_o}, 32'd0);
    chk("mr_rd0", {28'd0, fifo_rd_o}, 32'h0);
    q[1].push_back(8'hF0);
    q[3].push_back(8'hF3);
    refresh();
    tick();
    rst_n_i = 1'b1; #1;
    tick();  chk("mr_regrant", {28'd0, fifo_rd_o}, 32'h2);
    tick();  chk_out("mr_f0", 1'b1, 8'hF0, 2'd1);
    tick();  chk_out("mr_exit", 1'b0, 8'h00, 2'd0);
    tick();  chk("mr_next", {28'd0, fifo_rd_o}, 32'h4);
    tick();  chk_out("mr_d2", 1'b1, 8'hD2, 2'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_rr_reader.md
FIFO_RR_READER -- requirements
Module: fifo_rr_reader

Interface
REQ-001 The block SHALL have parameter CH_AMOUNT, default 4, setting the number of source FIFOs (2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, setting the word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4, setting the maximum number of words popped per grant (1..255).
REQ-004 The block SHALL have parameter CH_WIDTH, default $clog2( CH_AMOUNT ), setting the channel index width.
REQ-005 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port fifo_empty_i, input, CH_AMOUNT bits: per-channel show-ahead FIFO empty flag.
REQ-008 The block SHALL have port fifo_data_i, input, CH_AMOUNT*DATA_WIDTH bits: per-channel head word, with channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 The block SHALL have port fifo_rd_o, input-side pop strobe, output, CH_AMOUNT bits: per-channel pop, one cycle per word.
REQ-010 The block SHALL have port data_o, output, DATA_WIDTH bits: output word.
REQ-011 The block SHALL have port ch_o, output, CH_WIDTH bits: source channel of data_o.
REQ-012 The block SHALL have port valid_o, output, 1 bit: data_o/ch_o are valid.
REQ-013 The block SHALL have port ready_i, input, 1 bit: the sink accepts the word when valid_o && ready_i.
REQ-014 The block SHALL have port busy_o, output, 1 bit: high while in state GRANT.

Function
REQ-015 The FSM SHALL have two states, IDLE and GRANT; reset state is IDLE.
REQ-016 In IDLE, if any fifo_empty_i bit is 0, the block SHALL select the first non-empty channel searching from (last_grant+1) mod CH_AMOUNT upward with wrap-around, register it as grant, store it as last_grant, clear the burst counter, and enter GRANT on the next cycle.
REQ-017 In IDLE, fifo_rd_o SHALL be all zeros.
REQ-018 An output slot SHALL be free when valid_o==0 or ready_i==1.
REQ-019 In GRANT, fifo_rd_o[grant] SHALL be driven combinationally as (slot free && !fifo_empty_i[grant]); all other bits SHALL be 0.
REQ-020 fifo_rd_o SHALL never be asserted for an empty channel, and never for more than one channel at a time.
REQ-021 On a pop, the block SHALL load data_o <= fifo_data_i[grant] and ch_o <= grant, set valid_o <= 1, and increment the burst counter.
REQ-022 When the slot is free and no pop occurs, the block SHALL clear valid_o; data_o and ch_o SHALL hold.
REQ-023 While valid_o && !ready_i, data_o, ch_o and valid_o SHALL be stable.
REQ-024 GRANT SHALL return to IDLE when a pop brings the burst counter to BURST_LEN, or when fifo_empty_i[grant]==1.
REQ-025 Latency SHALL be as follows: with a channel going non-empty at cycle 0 and ready_i=1, grant occurs at edge 1, the pop at cycle 1, and valid_o=1 from edge 2.
REQ-026 Sustained throughput SHALL be one word per cycle within a burst, plus one IDLE cycle between grants.
REQ-027 The burst counter SHALL be $clog2(BURST_LEN+1) bits wide and SHALL NOT wrap.

Reset
REQ-028 On rst_n_i==0, the block SHALL asynchronously set the state to IDLE, valid_o=0, data_o=0, ch_o=0, burst counter=0, and last_grant=CH_AMOUNT-1, so that channel 0 has first priority; fifo_rd_o SHALL be 0.
REQ-029 Reset mid-burst SHALL discard any held output word; the source FIFOs are not rewound.

Verification
REQ-030 Reset and priority: release reset with fifo_empty_i=4'b1010 -> grant ch0 first; busy_o=1 one cycle after non-empty; all outputs 0 during reset.
REQ-031 Burst limit: ch1 holds 6 words (A..F), ready_i=1 -> A..D on consecutive cycles with ch_o=1, one IDLE cycle, then E,F with ch_o=1.
REQ-032 Round-robin order: all four channels hold 2 words each -> order ch0,ch0,ch1,ch1,ch2,ch2,ch3,ch3; after ch3 grant, ch0 is next.
REQ-033 Backpressure: ready_i=0 for 5 cycles while valid_o=1 -> data_o/ch_o unchanged, fifo_rd_o=0 throughout, no word lost or duplicated after ready_i returns to 1.
REQ-034 Early exit: ch2 holds 2 words, BURST_LEN=4 -> 2 pops, fifo_empty_i[2]=1 returns the FSM to IDLE, and no pop is issued while empty.
REQ-035 Reset mid-burst: assert rst_n_i after 2 of 4 pops -> valid_o=0 immediately; after release, the next grant is to the lowest non-empty channel starting at ch0.
